// File: rtl/sweep_pkg.sv
// Shared types and helpers for the exhaustive vector sweep sequencer.
package sweep_pkg;

    typedef enum logic [2:0] {IDLE, DRST, SETTLE, EMIT, FIN} sweep_state_e;

    localparam int unsigned CNT_W = 8;

    // Highest vector of an n_in-bit sweep.
    function automatic int unsigned last_vec(input int unsigned n_in);
        return (32'd1 << n_in) - 32'd1;
    endfunction

endpackage

// File: rtl/vector_sweep_ctrl_if.sv
// Record stream from the sweep sequencer to the result logger.
interface vector_sweep_ctrl_if #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 1
);
    logic             rec_valid;
    logic             rec_ready;
    logic [N_IN-1:0]  rec_vec;
    logic [N_OUT-1:0] rec_out;
    logic             rec_last;

    modport master (output rec_valid, rec_vec, rec_out, rec_last, input rec_ready);
    modport slave  (input rec_valid, rec_vec, rec_out, rec_last, output rec_ready);
endinterface

// File: rtl/sweep_timer.sv
// Loadable down-counter timing both the DUT reset phase and the per-vector settle phase.
module sweep_timer
    import sweep_pkg::CNT_W;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire_c
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (load)         cnt <= load_val;
        else if (cnt != '0)    cnt <= cnt - CNT_W'(1);
    end

    assign expire_c = (cnt == '0);
endmodule

// File: rtl/vector_sweep_ctrl.sv
// Sweeps every N_IN-bit vector into a DUT after resetting it, and streams {vector, response} records.
module vector_sweep_ctrl
    import sweep_pkg::sweep_state_e;
    import sweep_pkg::CNT_W;
    import sweep_pkg::last_vec;
#(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned N_OUT   = 1,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned RST_CYC = 1
) (
    input  logic               CK,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               dut_rst,
    output logic [N_IN-1:0]    dut_in,
    input  logic [N_OUT-1:0]   dut_out,
    vector_sweep_ctrl_if.master rec
);
    // One spare bit so the last vector never aliases to zero.
    localparam int unsigned     VW        = N_IN + 1;
    localparam logic [VW-1:0]   LAST      = VW'(last_vec(N_IN));
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);

    sweep_state_e     state, state_n;
    logic [VW-1:0]    vec, vec_n;
    logic [N_IN-1:0]  dut_in_n;
    logic             rec_valid;
    logic [N_IN-1:0]  rec_vec, rec_vec_n;
    logic [N_OUT-1:0] rec_out, rec_out_n;
    logic             rec_last, rec_last_n;
    logic             load, expire_c, aborting_c;
    logic [CNT_W-1:0] load_val;

    sweep_timer u_timer (
        .clk      (CK),
        .rst_n    (reset),
        .load     (load),
        .load_val (load_val),
        .expire_c (expire_c)
    );

    assign aborting_c = abort && (state != sweep_pkg::IDLE);

    // Next state, capture and timer control.
    always_comb begin
        state_n    = state;
        vec_n      = vec;
        rec_vec_n  = rec_vec;
        rec_out_n  = rec_out;
        rec_last_n = rec_last;
        load       = 1'b0;
        load_val   = '0;
        dut_in_n   = dut_in;
        case (state)
            sweep_pkg::IDLE: begin
                if (start && !abort) begin
                    state_n  = sweep_pkg::DRST;
                    vec_n    = '0;
                    load     = 1'b1;
                    load_val = RST_LD;
                end
            end
            sweep_pkg::DRST: begin
                if (expire_c) begin
                    state_n  = sweep_pkg::SETTLE;
                    load     = 1'b1;
                    load_val = SETTLE_LD;
                end
            end
            sweep_pkg::SETTLE: begin
                if (expire_c) begin
                    state_n    = sweep_pkg::EMIT;
                    rec_vec_n  = vec[N_IN-1:0];
                    rec_out_n  = dut_out;
                    rec_last_n = (vec == LAST);
                end
            end
            sweep_pkg::EMIT: begin
                if (rec.rec_ready) begin
                    if (rec_last) begin
                        state_n = sweep_pkg::FIN;
                    end else begin
                        state_n  = sweep_pkg::SETTLE;
                        vec_n    = vec + VW'(1);
                        load     = 1'b1;
                        load_val = SETTLE_LD;
                    end
                end
            end
            sweep_pkg::FIN: state_n = sweep_pkg::IDLE;
            default:        state_n = sweep_pkg::IDLE;
        endcase
        if (aborting_c) state_n = sweep_pkg::IDLE;

        // Stimulus follows the state being entered; FIN/IDLE keep the last vector.
        case (state_n)
            sweep_pkg::DRST:                     dut_in_n = '0;
            sweep_pkg::SETTLE, sweep_pkg::EMIT:  dut_in_n = vec_n[N_IN-1:0];
            default:                             dut_in_n = dut_in;
        endcase
        if (aborting_c) dut_in_n = '0;
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state     <= sweep_pkg::IDLE;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dut_rst   <= 1'b0;
            dut_in    <= '0;
            rec_valid <= 1'b0;
            rec_vec   <= '0;
            rec_out   <= '0;
            rec_last  <= 1'b0;
        end else begin
            state     <= state_n;
            vec       <= vec_n;
            busy      <= (state_n != sweep_pkg::IDLE);
            done      <= (state_n == sweep_pkg::FIN);
            dut_rst   <= (state_n == sweep_pkg::DRST);
            dut_in    <= dut_in_n;
            rec_valid <= (state_n == sweep_pkg::EMIT);
            rec_vec   <= rec_vec_n;
            rec_out   <= rec_out_n;
            rec_last  <= rec_last_n;
        end
    end

    assign rec.rec_valid = rec_valid;
    assign rec.rec_vec   = rec_vec;
    assign rec.rec_out   = rec_out;
    assign rec.rec_last  = rec_last;
endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Directed bench for vector_sweep_ctrl: table-checked sweeps plus backpressure, abort and reset sequences.
module tb_vector_sweep_ctrl;

    logic CK = 1'b0;
    logic reset = 1'b0;
    always #5 CK = ~CK;

    // Instance A: SETTLE=2, DUT is bit0 identity or a registered parity.
    logic       start_a = 0, abort_a = 0, ready_a = 1, reg_mode = 0;
    logic       busy_a, done_a, dut_rst_a, dut_out_a, par_a;
    logic [3:0] dut_in_a;
    // Instance B: SETTLE=1, registered parity DUT.
    logic       start_b = 0, abort_b = 0, ready_b = 1;
    logic       busy_b, done_b, dut_rst_b, par_b;
    logic [3:0] dut_in_b;

    vector_sweep_ctrl_if #(.N_IN(4), .N_OUT(1)) rec_a ();
    vector_sweep_ctrl_if #(.N_IN(4), .N_OUT(1)) rec_b ();
    assign rec_a.rec_ready = ready_a;
    assign rec_b.rec_ready = ready_b;

    always @(posedge CK) par_a <= dut_rst_a ? 1'b0 : ^dut_in_a;
    always @(posedge CK) par_b <= dut_rst_b ? 1'b0 : ^dut_in_b;
    assign dut_out_a = reg_mode ? par_a : dut_in_a[0];

    vector_sweep_ctrl #(.N_IN(4), .N_OUT(1), .SETTLE(2), .RST_CYC(1)) u_a (
        .CK(CK), .reset(reset), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
        .dut_rst(dut_rst_a), .dut_in(dut_in_a), .dut_out(dut_out_a), .rec(rec_a));

    vector_sweep_ctrl #(.N_IN(4), .N_OUT(1), .SETTLE(1), .RST_CYC(1)) u_b (
        .CK(CK), .reset(reset), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
        .dut_rst(dut_rst_b), .dut_in(dut_in_b), .dut_out(par_b), .rec(rec_b));

    typedef struct {
        logic [3:0] vec;
        logic       out_id;
        logic       out_par;
        logic       out_prev;
        logic       last;
    } vec_rec_t;
    vec_rec_t tbl [16];

    // Passive monitor on the falling edge; inputs only change just after rising edges.
    logic [5:0] q_a [$];
    logic [5:0] q_b [$];
    int busy_cyc_a = 0, done_cnt_a = 0, done_cnt_b = 0;
    always @(negedge CK) begin
        if (rec_a.rec_valid && ready_a && !abort_a) q_a.push_back({rec_a.rec_vec, rec_a.rec_out, rec_a.rec_last});
        if (rec_b.rec_valid && ready_b && !abort_b) q_b.push_back({rec_b.rec_vec, rec_b.rec_out, rec_b.rec_last});
        busy_cyc_a += int'(busy_a);
        done_cnt_a += int'(done_a);
        done_cnt_b += int'(done_b);
    end

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy_a || busy_b) && n < 300) begin tick(); n++; end
        chk({nm, "_idle_timeout"}, int'(busy_a || busy_b), 0);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!rec_a.rec_valid && n < 50) begin tick(); n++; end
        chk({nm, "_valid_timeout"}, int'(rec_a.rec_valid), 1);
    endtask

    task automatic check_records(input string nm, input int base, input int which);
        int got;
        logic [5:0] a, e;
        logic eo;
        got = (which == 2) ? q_b.size() - base : q_a.size() - base;
        chk({nm, "_count"}, got, 16);
        for (int i = 0; i < 16; i++) begin
            if (i < got) begin
                a  = (which == 2) ? q_b[base + i] : q_a[base + i];
                eo = (which == 0) ? tbl[i].out_id : (which == 1) ? tbl[i].out_par : tbl[i].out_prev;
                e  = {tbl[i].vec, eo, tbl[i].last};
                chk($sformatf("%s_rec%0d", nm, i), int'(a), int'(e));
            end
        end
    endtask

    initial begin
        int base, base_b, d0, b0, n;
        logic [3:0] pv;
        for (int i = 0; i < 16; i++) begin
            tbl[i].vec     = 4'(i);
            tbl[i].out_id  = tbl[i].vec[0];
            tbl[i].out_par = ^tbl[i].vec;
            pv             = 4'(i - 1);
            tbl[i].out_prev = (i == 0) ? 1'b0 : ^pv;
            tbl[i].last    = (i == 15);
        end

        // Reset state
        #22;
        chk("reset_ctrl", int'({busy_a, done_a, dut_rst_a, rec_a.rec_valid, rec_a.rec_last}), 0);
        chk("reset_data", int'({dut_in_a, rec_a.rec_vec, rec_a.rec_out}), 0);
        reset = 1'b1;
        tick();
        chk("idle_after_reset", int'(busy_a), 0);

        // 1: full sweep with ready high
        base = q_a.size(); d0 = done_cnt_a; b0 = busy_cyc_a;
        start_a = 1; tick(); start_a = 0;
        chk("drst_entry", int'({busy_a, dut_rst_a, dut_in_a}), int'({1'b1, 1'b1, 4'd0}));
        n = 0;
        while (!rec_a.rec_valid && n < 20) begin tick(); n++; end
        chk("first_valid_latency", n, 3);
        wait_idle("t1");
        check_records("t1", base, 0);
        chk("t1_busy_cycles", busy_cyc_a - b0, 50);
        chk("t1_done_pulses", done_cnt_a - d0, 1);
        chk("t1_dut_in_held", int'(dut_in_a), 15);

        // 2: backpressure on vector 3
        ready_a = 0; base = q_a.size(); d0 = done_cnt_a;
        start_a = 1; tick(); start_a = 0;
        for (int r = 0; r < 16; r++) begin
            wait_valid("t2");
            if (rec_a.rec_vec == 4'd3) begin
                for (int k = 0; k < 5; k++) begin
                    chk($sformatf("t2_hold%0d", k),
                        int'({rec_a.rec_valid, rec_a.rec_vec, rec_a.rec_out, dut_in_a}),
                        int'({1'b1, 4'd3, 1'b1, 4'd3}));
                    tick();
                end
                ready_a = 1; tick(); ready_a = 0;
                chk("t2_release", int'({rec_a.rec_valid, dut_in_a}), int'({1'b0, 4'd4}));
            end else begin
                ready_a = 1; tick(); ready_a = 0;
            end
        end
        ready_a = 1;
        wait_idle("t2");
        check_records("t2", base, 0);
        chk("t2_done_pulses", done_cnt_a - d0, 1);

        // 3: abort during SETTLE of vector 7, then restart
        d0 = done_cnt_a;
        start_a = 1; tick(); start_a = 0;
        n = 0;
        while (!(dut_in_a == 4'd7 && !rec_a.rec_valid) && n < 100) begin tick(); n++; end
        chk("t3_reach_vec7", int'(dut_in_a), 7);
        abort_a = 1; tick(); abort_a = 0;
        chk("t3_abort", int'({busy_a, rec_a.rec_valid, dut_rst_a, dut_in_a}), 0);
        tick(); tick(); tick();
        chk("t3_no_done", done_cnt_a - d0, 0);
        base = q_a.size();
        start_a = 1; tick(); start_a = 0;
        chk("t3_restart_drst", int'({busy_a, dut_rst_a, dut_in_a}), int'({1'b1, 1'b1, 4'd0}));
        wait_idle("t3");
        check_records("t3", base, 0);

        // 3b: abort coincident with rec_ready
        ready_a = 0; d0 = done_cnt_a;
        start_a = 1; tick(); start_a = 0;
        wait_valid("t3b");
        ready_a = 1; abort_a = 1; tick(); abort_a = 0;
        chk("t3b_abort_wins", int'({busy_a, rec_a.rec_valid, dut_in_a}), 0);
        tick(); tick();
        chk("t3b_no_done", done_cnt_a - d0, 0);

        // 3c: start and abort together in IDLE
        start_a = 1; abort_a = 1; tick(); start_a = 0; abort_a = 0;
        chk("t3c_stay_idle", int'({busy_a, dut_rst_a}), 0);

        // 4: asynchronous reset mid-EMIT
        ready_a = 0;
        start_a = 1; tick(); start_a = 0;
        wait_valid("t4");
        #2 reset = 1'b0;
        #1;
        chk("t4_async_ctrl", int'({busy_a, done_a, dut_rst_a, rec_a.rec_valid, rec_a.rec_last}), 0);
        chk("t4_async_data", int'({dut_in_a, rec_a.rec_vec, rec_a.rec_out}), 0);
        tick(); tick();
        reset = 1'b1; ready_a = 1;
        tick(); tick(); tick();
        chk("t4_idle_after_release", int'({busy_a, rec_a.rec_valid}), 0);

        // 5: start re-pulsed while busy at vector 9
        base = q_a.size(); d0 = done_cnt_a;
        start_a = 1; tick(); start_a = 0;
        n = 0;
        while (dut_in_a != 4'd9 && n < 100) begin tick(); n++; end
        chk("t5_reach_vec9", int'(dut_in_a), 9);
        start_a = 1; tick(); start_a = 0;
        wait_idle("t5");
        check_records("t5", base, 0);
        chk("t5_done_pulses", done_cnt_a - d0, 1);

        // 6: registered DUT, SETTLE=2 on A versus SETTLE=1 on B
        reg_mode = 1; base = q_a.size(); base_b = q_b.size(); d0 = done_cnt_b;
        start_a = 1; start_b = 1; tick(); start_a = 0; start_b = 0;
        wait_idle("t6");
        check_records("t6_settle2", base, 1);
        check_records("t6_settle1", base_b, 2);
        chk("t6_b_done_pulses", done_cnt_b - d0, 1);
        reg_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
